// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to sprite mappers, palette stages and VGA pins.
interface vga_timing_gen_if;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned FC_W  = 8;

    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             blank;
    logic             hs;
    logic             vs;
    logic             line_end;
    logic             frame_end;
    logic [FC_W-1:0]  frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_end, frame_end, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, line_end, frame_end, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with coordinate outputs, blanking, line/frame strobes,
// a frame counter and active-low syncs delayed to line up with downstream colour data.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master o_vga
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FC_W    = 8;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_S_LO  = H_ACTIVE + H_FP;
    localparam int unsigned H_S_HI  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_S_LO  = V_ACTIVE + V_FP;
    localparam int unsigned V_S_HI  = V_ACTIVE + V_FP + V_SYNC;

    // Reject geometries the 10-bit counters cannot represent, and over-deep sync pipes.
    if (H_TOTAL > 1024) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (PIPE_DELAY > 7) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic [FC_W-1:0]  r_frame_count;

    logic       w_line_end;
    logic       w_frame_end;
    logic       w_blank;
    logic [1:0] w_sync_raw;   // {vsync_n, hsync_n} for the current coordinate
    logic [1:0] w_sync_out;

    // Raster decode straight from the counter registers (compared at 32 bits to avoid truncation).
    assign w_line_end    = (32'(r_hc) == H_TOTAL - 1);
    assign w_frame_end   = w_line_end && (32'(r_vc) == V_TOTAL - 1);
    assign w_blank       = (32'(r_hc) < H_ACTIVE) && (32'(r_vc) < V_ACTIVE);
    assign w_sync_raw[0] = !((32'(r_hc) >= H_S_LO) && (32'(r_hc) < H_S_HI));
    assign w_sync_raw[1] = !((32'(r_vc) >= V_S_LO) && (32'(r_vc) < V_S_HI));

    // Horizontal/vertical counters and completed-frame counter.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_line_end) begin
                r_hc <= '0;
                r_vc <= w_frame_end ? '0 : r_vc + CNT_W'(1);
            end else begin
                r_hc <= r_hc + CNT_W'(1);
            end
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + FC_W'(1);
            end
        end
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign w_sync_out = w_sync_raw;
    end else begin : g_pipe
        localparam int unsigned PIPE_W = 2 * PIPE_DELAY;

        logic [PIPE_W-1:0] r_sync_pipe;

        // Sync delay line; newest pair enters at the bottom, oldest falls off the top.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync_pipe <= '1;
            end else begin
                r_sync_pipe <= PIPE_W'({r_sync_pipe, w_sync_raw});
            end
        end

        assign w_sync_out = r_sync_pipe[PIPE_W-1 -: 2];
    end

    assign o_vga.DrawX       = r_hc;
    assign o_vga.DrawY       = r_vc;
    assign o_vga.blank       = w_blank;
    assign o_vga.hs          = w_sync_out[0];
    assign o_vga.vs          = w_sync_out[1];
    assign o_vga.line_end    = w_line_end;
    assign o_vga.frame_end   = w_frame_end;
    assign o_vga.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three full-size instances (sync delay 0, 2, 7) and one
// reduced 8x5 raster instance (delay 1) share clock and reset; a behavioural raster model
// feeds per-instance sync queues whose popped entries are the expected delayed syncs.
module tb_vga_timing_gen;

    localparam int FH_TOT = 800;
    localparam int FV_TOT = 525;
    localparam int SH_TOT = 8;
    localparam int SV_TOT = 5;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       le;
        logic       fe;
        logic [7:0] fc;
    } snap_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    int errors = 0;
    int checks = 0;

    vga_timing_gen_if if_d0();
    vga_timing_gen_if if_d2();
    vga_timing_gen_if if_d7();
    vga_timing_gen_if if_sm();

    vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (.vga_clk(vga_clk), .reset_n(reset_n), .o_vga(if_d0));
    vga_timing_gen #(.PIPE_DELAY(2)) u_d2 (.vga_clk(vga_clk), .reset_n(reset_n), .o_vga(if_d2));
    vga_timing_gen #(.PIPE_DELAY(7)) u_d7 (.vga_clk(vga_clk), .reset_n(reset_n), .o_vga(if_d7));
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PIPE_DELAY(1)
    ) u_sm (.vga_clk(vga_clk), .reset_n(reset_n), .o_vga(if_sm));

    snap_t sn [4];
    string nm [4] = '{"d0", "d2", "d7", "sm"};

    assign sn[0] = {if_d0.DrawX, if_d0.DrawY, if_d0.blank, if_d0.hs, if_d0.vs,
                    if_d0.line_end, if_d0.frame_end, if_d0.frame_count};
    assign sn[1] = {if_d2.DrawX, if_d2.DrawY, if_d2.blank, if_d2.hs, if_d2.vs,
                    if_d2.line_end, if_d2.frame_end, if_d2.frame_count};
    assign sn[2] = {if_d7.DrawX, if_d7.DrawY, if_d7.blank, if_d7.hs, if_d7.vs,
                    if_d7.line_end, if_d7.frame_end, if_d7.frame_count};
    assign sn[3] = {if_sm.DrawX, if_sm.DrawY, if_sm.blank, if_sm.hs, if_sm.vs,
                    if_sm.line_end, if_sm.frame_end, if_sm.frame_count};

    always #5 vga_clk = ~vga_clk;

    // Behavioural raster model and sync scoreboards ({vs_n, hs_n} entries).
    int m_hc, m_vc, m_fc;
    int s_hc, s_vc, s_fc;
    logic [1:0] q2 [$];
    logic [1:0] q7 [$];
    logic [1:0] qs [$];
    logic [1:0] e0, e2, e7, es;

    function automatic logic [1:0] f_sync_full(int hc, int vc);
        logic hs_n, vs_n;
        hs_n = !(hc >= 656 && hc <= 751);
        vs_n = !(vc >= 490 && vc <= 491);
        return {vs_n, hs_n};
    endfunction

    function automatic logic [1:0] f_sync_small(int hc, int vc);
        logic hs_n, vs_n;
        hs_n = !(hc >= 5 && hc <= 6);
        vs_n = !(vc == 3);
        return {vs_n, hs_n};
    endfunction

    task automatic sb_update();
        e0 = f_sync_full(m_hc, m_vc);
        q2.push_back(e0);
        q7.push_back(e0);
        qs.push_back(f_sync_small(s_hc, s_vc));
        e2 = q2.pop_front();
        e7 = q7.pop_front();
        es = qs.pop_front();
    endtask

    task automatic sb_reset();
        m_hc = 0; m_vc = 0; m_fc = 0;
        s_hc = 0; s_vc = 0; s_fc = 0;
        q2.delete(); q7.delete(); qs.delete();
        repeat (2) q2.push_back(2'b11);
        repeat (7) q7.push_back(2'b11);
        qs.push_back(2'b11);
        sb_update();
    endtask

    // One pixel clock: advance the model at the edge, then land on the sampling (falling) edge.
    task automatic tick();
        @(posedge vga_clk);
        if (reset_n) begin
            if (m_hc == FH_TOT - 1) begin
                m_hc = 0;
                if (m_vc == FV_TOT - 1) begin
                    m_vc = 0;
                    m_fc = (m_fc + 1) % 256;
                end else begin
                    m_vc++;
                end
            end else begin
                m_hc++;
            end
            if (s_hc == SH_TOT - 1) begin
                s_hc = 0;
                if (s_vc == SV_TOT - 1) begin
                    s_vc = 0;
                    s_fc = (s_fc + 1) % 256;
                end else begin
                    s_vc++;
                end
            end else begin
                s_hc++;
            end
        end
        sb_update();
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sb_reset();
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sn[i].x !== 10'd0 || sn[i].y !== 10'd0) begin
                errors++;
                $display("FAIL reset_xy_%s: got (%0d,%0d) expected (0,0)", nm[i], sn[i].x, sn[i].y);
            end
            checks++;
            if (sn[i].blank !== 1'b1 || sn[i].hs !== 1'b1 || sn[i].vs !== 1'b1) begin
                errors++;
                $display("FAIL reset_sync_%s: got blank=%0b hs=%0b vs=%0b expected 1 1 1",
                         nm[i], sn[i].blank, sn[i].hs, sn[i].vs);
            end
            checks++;
            if (sn[i].le !== 1'b0 || sn[i].fe !== 1'b0 || sn[i].fc !== 8'd0) begin
                errors++;
                $display("FAIL reset_strobes_%s: got le=%0b fe=%0b fc=%0d expected 0 0 0",
                         nm[i], sn[i].le, sn[i].fe, sn[i].fc);
            end
        end
        reset_n = 1'b1;
        checks++;
        if (sn[0].x !== 10'd0) begin
            errors++;
            $display("FAIL release_hold: got DrawX=%0d expected 0 before first edge", sn[0].x);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sn[i].x !== 10'd1 || sn[i].y !== 10'd0) begin
                errors++;
                $display("FAIL release_first_edge_%s: got (%0d,%0d) expected (1,0)", nm[i], sn[i].x, sn[i].y);
            end
        end
    endtask

    task automatic test_hsync_pipeline();
        logic [2:0] prev_hs;
        logic [2:0] cur_hs;
        int fall [3];
        int rise [3];
        int exp_fall [3] = '{656, 658, 663};
        int exp_rise [3] = '{752, 754, 759};
        int n_le;
        prev_hs = {sn[2].hs, sn[1].hs, sn[0].hs};
        fall = '{-1, -1, -1};
        rise = '{-1, -1, -1};
        n_le = 0;
        for (int n = 0; n < 2 * FH_TOT; n++) begin
            tick();
            checks++;
            if (sn[0].x !== 10'(m_hc) || sn[0].y !== 10'(m_vc)) begin
                errors++;
                $display("FAIL coord_d0: got (%0d,%0d) expected (%0d,%0d)", sn[0].x, sn[0].y, m_hc, m_vc);
            end
            checks++;
            if (sn[0].blank !== (m_hc < 640 && m_vc < 480)) begin
                errors++;
                $display("FAIL blank_d0: got %0b at hc=%0d vc=%0d", sn[0].blank, m_hc, m_vc);
            end
            checks++;
            if (sn[0].le !== (m_hc == FH_TOT - 1)) begin
                errors++;
                $display("FAIL line_end_d0: got %0b at hc=%0d", sn[0].le, m_hc);
            end
            checks++;
            if (sn[0].hs !== e0[0] || sn[0].vs !== e0[1]) begin
                errors++;
                $display("FAIL sync_d0: got hs=%0b vs=%0b expected %0b %0b at hc=%0d", sn[0].hs, sn[0].vs, e0[0], e0[1], m_hc);
            end
            checks++;
            if (sn[1].hs !== e2[0] || sn[1].vs !== e2[1]) begin
                errors++;
                $display("FAIL sync_d2: got hs=%0b vs=%0b expected %0b %0b at hc=%0d", sn[1].hs, sn[1].vs, e2[0], e2[1], m_hc);
            end
            checks++;
            if (sn[2].hs !== e7[0] || sn[2].vs !== e7[1]) begin
                errors++;
                $display("FAIL sync_d7: got hs=%0b vs=%0b expected %0b %0b at hc=%0d", sn[2].hs, sn[2].vs, e7[0], e7[1], m_hc);
            end
            cur_hs = {sn[2].hs, sn[1].hs, sn[0].hs};
            for (int i = 0; i < 3; i++) begin
                if (prev_hs[i] && !cur_hs[i] && fall[i] < 0) fall[i] = m_hc;
                if (!prev_hs[i] && cur_hs[i] && rise[i] < 0) rise[i] = m_hc;
            end
            prev_hs = cur_hs;
            if (sn[0].le) n_le++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fall[i] != exp_fall[i] || rise[i] != exp_rise[i]) begin
                errors++;
                $display("FAIL hs_edges_%s: got fall@%0d rise@%0d expected fall@%0d rise@%0d",
                         nm[i], fall[i], rise[i], exp_fall[i], exp_rise[i]);
            end
        end
        checks++;
        if (n_le != 2) begin
            errors++;
            $display("FAIL line_end_count: got %0d expected 2", n_le);
        end
    endtask

    task automatic test_vsync_wrap();
        logic prev_vs;
        logic [9:0] px, py;
        int n_fe, n_vs_low;
        prev_vs = sn[3].vs;
        px = sn[3].x;
        py = sn[3].y;
        n_fe = 0;
        n_vs_low = 0;
        for (int n = 0; n < 2 * SH_TOT * SV_TOT; n++) begin
            tick();
            checks++;
            if (sn[3].x !== 10'(s_hc) || sn[3].y !== 10'(s_vc)) begin
                errors++;
                $display("FAIL coord_sm: got (%0d,%0d) expected (%0d,%0d)", sn[3].x, sn[3].y, s_hc, s_vc);
            end
            checks++;
            if (sn[3].hs !== es[0] || sn[3].vs !== es[1]) begin
                errors++;
                $display("FAIL sync_sm: got hs=%0b vs=%0b expected %0b %0b at (%0d,%0d)", sn[3].hs, sn[3].vs, es[0], es[1], s_hc, s_vc);
            end
            checks++;
            if (sn[3].blank !== (s_hc < 4 && s_vc < 2)) begin
                errors++;
                $display("FAIL blank_sm: got %0b at (%0d,%0d)", sn[3].blank, s_hc, s_vc);
            end
            checks++;
            if (sn[3].fe !== (s_hc == SH_TOT - 1 && s_vc == SV_TOT - 1) || sn[3].fc !== 8'(s_fc)) begin
                errors++;
                $display("FAIL frame_sm: got fe=%0b fc=%0d expected fc=%0d at (%0d,%0d)", sn[3].fe, sn[3].fc, s_fc, s_hc, s_vc);
            end
            if (px == 10'd7 && py == 10'd4) begin
                checks++;
                if (sn[3].x !== 10'd0 || sn[3].y !== 10'd0) begin
                    errors++;
                    $display("FAIL frame_wrap_sm: got (%0d,%0d) after (7,4) expected (0,0)", sn[3].x, sn[3].y);
                end
            end
            if (sn[3].vs !== prev_vs) begin
                checks++;
                if (sn[3].x !== 10'd1) begin
                    errors++;
                    $display("FAIL vs_edge_sm: got vs change at DrawX=%0d expected DrawX=1", sn[3].x);
                end
            end
            if (sn[3].fe) n_fe++;
            if (!sn[3].vs) n_vs_low++;
            prev_vs = sn[3].vs;
            px = sn[3].x;
            py = sn[3].y;
        end
        checks++;
        if (n_fe != 2 || n_vs_low != 2 * SH_TOT) begin
            errors++;
            $display("FAIL vsync_counts_sm: got fe=%0d vs_low=%0d expected 2 and %0d", n_fe, n_vs_low, 2 * SH_TOT);
        end
    endtask

    task automatic test_frame_count_wrap();
        int n_fe;
        reset_n = 1'b0;
        sb_reset();
        tick();
        reset_n = 1'b1;
        n_fe = 0;
        for (int n = 0; n < 256 * SH_TOT * SV_TOT; n++) begin
            tick();
            if (sn[3].fe) begin
                n_fe++;
                checks++;
                if (sn[3].fc !== 8'(n_fe - 1)) begin
                    errors++;
                    $display("FAIL fc_at_frame_end: got %0d expected %0d on pulse %0d", sn[3].fc, (n_fe - 1) % 256, n_fe);
                end
            end
            if (n_fe == 256 && sn[3].fe) begin
                checks++;
                if (sn[3].fc !== 8'd255) begin
                    errors++;
                    $display("FAIL fc_before_wrap: got %0d expected 255", sn[3].fc);
                end
            end
        end
        checks++;
        if (n_fe != 256) begin
            errors++;
            $display("FAIL frame_end_count: got %0d expected 256", n_fe);
        end
        checks++;
        if (sn[3].fc !== 8'd0 || sn[3].fc !== 8'(s_fc)) begin
            errors++;
            $display("FAIL fc_after_wrap: got %0d expected 0", sn[3].fc);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        guard = 0;
        while ((s_fc < 2 || m_hc != 700) && guard < 2000) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL mid_reset_setup: got no (700,y) point with fc>=2 within 2000 cycles");
        end
        checks++;
        if (sn[2].hs !== e7[0] || sn[3].fc !== 8'(s_fc)) begin
            errors++;
            $display("FAIL mid_reset_pre: got d7 hs=%0b sm fc=%0d expected %0b %0d", sn[2].hs, sn[3].fc, e7[0], s_fc);
        end
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sn[i].x !== 10'd0 || sn[i].y !== 10'd0 || sn[i].fc !== 8'd0) begin
                errors++;
                $display("FAIL mid_reset_state_%s: got (%0d,%0d) fc=%0d expected (0,0) fc=0", nm[i], sn[i].x, sn[i].y, sn[i].fc);
            end
            checks++;
            if (sn[i].hs !== 1'b1 || sn[i].vs !== 1'b1 || sn[i].blank !== 1'b1 || sn[i].le !== 1'b0 || sn[i].fe !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_outs_%s: got hs=%0b vs=%0b blank=%0b le=%0b fe=%0b expected 1 1 1 0 0",
                         nm[i], sn[i].hs, sn[i].vs, sn[i].blank, sn[i].le, sn[i].fe);
            end
        end
        @(negedge vga_clk);
        sb_reset();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sn[i].x !== 10'd1 || sn[i].y !== 10'd0 || sn[i].fc !== 8'd0) begin
                errors++;
                $display("FAIL mid_reset_restart_%s: got (%0d,%0d) fc=%0d expected (1,0) fc=0", nm[i], sn[i].x, sn[i].y, sn[i].fc);
            end
        end
        checks++;
        if (sn[2].hs !== e7[0] || sn[1].hs !== e2[0]) begin
            errors++;
            $display("FAIL mid_reset_pipe: got d2 hs=%0b d7 hs=%0b expected %0b %0b", sn[1].hs, sn[2].hs, e2[0], e7[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge vga_clk);
        test_reset();
        test_hsync_pipeline();
        test_vsync_wrap();
        test_frame_count_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
